// File: rtl/lcd_win_streamer_pkg.sv
// Shared LCD constants (DCS opcodes, coordinate width) and the window streamer's
// state encoding and header helpers.
package lcd_defs;
    localparam int unsigned LCD_COORD_W = 9;
    localparam logic [7:0]  DCS_CASET   = 8'h2A;
    localparam logic [7:0]  DCS_RASET   = 8'h2B;
    localparam logic [7:0]  DCS_RAMWR   = 8'h2C;
endpackage

package lcd_win_streamer_pkg;
    import lcd_defs::*;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_HDR    = 2'd1;
    localparam logic [1:0] ST_PIX_HI = 2'd2;
    localparam logic [1:0] ST_PIX_LO = 2'd3;

    // Index of the final header byte (RAMWR opcode); the header is 11 bytes long.
    localparam logic [3:0] HDR_LAST  = 4'd10;

    // Coordinates go on the wire as 16-bit big-endian values, zero-extended.
    function automatic logic [7:0] coord_hi(input logic [LCD_COORD_W-1:0] c);
        logic [15:0] w_ext;
        w_ext = 16'(c);
        return w_ext[15:8];
    endfunction

    function automatic logic [7:0] coord_lo(input logic [LCD_COORD_W-1:0] c);
        logic [15:0] w_ext;
        w_ext = 16'(c);
        return w_ext[7:0];
    endfunction
endpackage

// File: rtl/lcd_win_streamer.sv
// Streams a CASET/RASET/RAMWR header and an RGB565 pixel window to an LCD byte PHY.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for a window request; output slot empty
// HDR       | emitting the 11 header bytes from the corner registers
// PIX_HI    | waiting for a pixel; its high byte goes out on transfer
// PIX_LO    | emitting the latched low byte; finishes after the last one
module lcd_win_streamer
    import lcd_defs::*;
    import lcd_win_streamer_pkg::*;
#(
    parameter logic [7:0] CMD_CASET = DCS_CASET,
    parameter logic [7:0] CMD_RASET = DCS_RASET,
    parameter logic [7:0] CMD_RAMWR = DCS_RAMWR
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [LCD_COORD_W-1:0] req_x0,
    input  logic [LCD_COORD_W-1:0] req_x1,
    input  logic [LCD_COORD_W-1:0] req_y0,
    input  logic [LCD_COORD_W-1:0] req_y1,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [15:0]            pix_data,
    input  logic                   pix_valid,
    output logic                   pix_ready,
    output logic [7:0]             phy_data,
    output logic                   phy_rs,
    output logic                   phy_valid,
    input  logic                   phy_ready,
    output logic                   busy,
    output logic                   done_stb,
    output logic                   err_stb
);

    logic [1:0]             r_state;
    logic                   r_started;
    logic [LCD_COORD_W-1:0] r_x0, r_x1, r_y0, r_y1;
    logic [LCD_COORD_W-1:0] r_col, r_row;
    logic [3:0]             r_hdr_idx;
    logic [7:0]             r_lo_byte;
    logic                   r_lo_sent;
    logic [7:0]             r_phy_data;
    logic                   r_phy_rs;
    logic                   r_phy_valid;
    logic                   r_done_err;

    logic       w_slot_free;
    logic       w_last_pix;
    logic       w_done_win;
    logic       w_req_bad;
    logic [7:0] w_hdr_data;
    logic       w_hdr_rs;

    assign w_slot_free = !r_phy_valid || phy_ready;
    assign w_last_pix  = (r_col == r_x1) && (r_row == r_y1);
    assign w_req_bad   = (req_x1 < req_x0) || (req_y1 < req_y0);
    assign w_done_win  = (r_state == ST_PIX_LO) && r_lo_sent && r_phy_valid && phy_ready;

    always_comb begin
        w_hdr_data = 8'h00;
        w_hdr_rs   = 1'b1;
        case (r_hdr_idx)
            4'd0:    begin w_hdr_data = CMD_CASET; w_hdr_rs = 1'b0; end
            4'd1:    w_hdr_data = coord_hi(r_x0);
            4'd2:    w_hdr_data = coord_lo(r_x0);
            4'd3:    w_hdr_data = coord_hi(r_x1);
            4'd4:    w_hdr_data = coord_lo(r_x1);
            4'd5:    begin w_hdr_data = CMD_RASET; w_hdr_rs = 1'b0; end
            4'd6:    w_hdr_data = coord_hi(r_y0);
            4'd7:    w_hdr_data = coord_lo(r_y0);
            4'd8:    w_hdr_data = coord_hi(r_y1);
            4'd9:    w_hdr_data = coord_lo(r_y1);
            4'd10:   begin w_hdr_data = CMD_RAMWR; w_hdr_rs = 1'b0; end
            default: w_hdr_data = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_started   <= 1'b0;
            r_x0        <= '0;
            r_x1        <= '0;
            r_y0        <= '0;
            r_y1        <= '0;
            r_col       <= '0;
            r_row       <= '0;
            r_hdr_idx   <= 4'd0;
            r_lo_byte   <= 8'h00;
            r_lo_sent   <= 1'b0;
            r_phy_data  <= 8'h00;
            r_phy_rs    <= 1'b0;
            r_phy_valid <= 1'b0;
            r_done_err  <= 1'b0;
        end else begin
            r_started  <= 1'b1;
            r_done_err <= 1'b0;
            if (r_phy_valid && phy_ready) begin
                r_phy_valid <= 1'b0;
            end
            case (r_state)
                ST_IDLE: begin
                    // r_hdr_idx is 0 here, so the mux already presents the CASET opcode.
                    if (req_valid && r_started) begin
                        if (w_req_bad) begin
                            r_done_err <= 1'b1;
                        end else begin
                            r_x0        <= req_x0;
                            r_x1        <= req_x1;
                            r_y0        <= req_y0;
                            r_y1        <= req_y1;
                            r_col       <= req_x0;
                            r_row       <= req_y0;
                            r_phy_data  <= w_hdr_data;
                            r_phy_rs    <= w_hdr_rs;
                            r_phy_valid <= 1'b1;
                            r_hdr_idx   <= 4'd1;
                            r_state     <= ST_HDR;
                        end
                    end
                end
                ST_HDR: begin
                    if (w_slot_free) begin
                        r_phy_data  <= w_hdr_data;
                        r_phy_rs    <= w_hdr_rs;
                        r_phy_valid <= 1'b1;
                        if (r_hdr_idx == HDR_LAST) begin
                            r_hdr_idx <= 4'd0;
                            r_state   <= ST_PIX_HI;
                        end else begin
                            r_hdr_idx <= r_hdr_idx + 4'd1;
                        end
                    end
                end
                ST_PIX_HI: begin
                    if (pix_valid && w_slot_free) begin
                        r_phy_data  <= pix_data[15:8];
                        r_phy_rs    <= 1'b1;
                        r_phy_valid <= 1'b1;
                        r_lo_byte   <= pix_data[7:0];
                        r_state     <= ST_PIX_LO;
                    end
                end
                ST_PIX_LO: begin
                    // After the final low byte is loaded, hold here until the PHY takes it.
                    if (!r_lo_sent) begin
                        if (w_slot_free) begin
                            r_phy_data  <= r_lo_byte;
                            r_phy_rs    <= 1'b1;
                            r_phy_valid <= 1'b1;
                            if (w_last_pix) begin
                                r_lo_sent <= 1'b1;
                            end else begin
                                if (r_col == r_x1) begin
                                    r_col <= r_x0;
                                    r_row <= r_row + 1'b1;
                                end else begin
                                    r_col <= r_col + 1'b1;
                                end
                                r_state <= ST_PIX_HI;
                            end
                        end
                    end else if (r_phy_valid && phy_ready) begin
                        r_lo_sent <= 1'b0;
                        r_state   <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign req_ready = r_started && (r_state == ST_IDLE);
    assign pix_ready = (r_state == ST_PIX_HI) && w_slot_free;
    assign busy      = (r_state != ST_IDLE);
    assign phy_data  = r_phy_data;
    assign phy_rs    = r_phy_rs;
    assign phy_valid = r_phy_valid;
    assign done_stb  = r_done_err || w_done_win;
    assign err_stb   = r_done_err;

endmodule

// File: tb/tb_lcd_win_streamer.sv
// Scoreboard bench for lcd_win_streamer: expected PHY bytes are queued when a window
// is requested and popped by an independent monitor on every PHY handshake.
module tb_lcd_win_streamer;
    import lcd_defs::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [8:0]  req_x0, req_x1, req_y0, req_y1;
    logic        req_valid, req_ready;
    logic [15:0] pix_data;
    logic        pix_valid, pix_ready;
    logic [7:0]  phy_data;
    logic        phy_rs, phy_valid, phy_ready;
    logic        busy, done_stb, err_stb;

    int checks = 0;
    int errors = 0;

    logic [8:0]  exp_q[$];
    logic [15:0] pix_q[$];
    int          exp_total;
    int          bytes_seen;
    int          ready_rate = 100;
    int          pix_rate   = 100;
    bit          manual_ready = 1'b0;
    bit          err_expected = 1'b0;
    bit          take;
    bit          hs;
    bit          prev_stall = 1'b0;
    logic [8:0]  prev_byte;
    logic [8:0]  popped;

    always #5 clk = ~clk;

    lcd_win_streamer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_x0   (req_x0),
        .req_x1   (req_x1),
        .req_y0   (req_y0),
        .req_y1   (req_y1),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .pix_data (pix_data),
        .pix_valid(pix_valid),
        .pix_ready(pix_ready),
        .phy_data (phy_data),
        .phy_rs   (phy_rs),
        .phy_valid(phy_valid),
        .phy_ready(phy_ready),
        .busy     (busy),
        .done_stb (done_stb),
        .err_stb  (err_stb)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: header from the corners, then every pixel of the window in
    // raster order as high byte then low byte.
    task automatic push_window(input int x0, input int x1, input int y0, input int y1);
        int         npix;
        logic [15:0] p;
        exp_q.push_back({1'b0, 8'h2A});
        exp_q.push_back({1'b1, 8'(x0 / 256)});
        exp_q.push_back({1'b1, 8'(x0 % 256)});
        exp_q.push_back({1'b1, 8'(x1 / 256)});
        exp_q.push_back({1'b1, 8'(x1 % 256)});
        exp_q.push_back({1'b0, 8'h2B});
        exp_q.push_back({1'b1, 8'(y0 / 256)});
        exp_q.push_back({1'b1, 8'(y0 % 256)});
        exp_q.push_back({1'b1, 8'(y1 / 256)});
        exp_q.push_back({1'b1, 8'(y1 % 256)});
        exp_q.push_back({1'b0, 8'h2C});
        npix = (x1 - x0 + 1) * (y1 - y0 + 1);
        for (int i = 0; i < npix; i++) begin
            p = 16'($urandom);
            pix_q.push_back(p);
            exp_q.push_back({1'b1, p[15:8]});
            exp_q.push_back({1'b1, p[7:0]});
        end
        exp_total  = 11 + 2 * npix;
        bytes_seen = 0;
    endtask

    task automatic issue_req(input int x0, input int x1, input int y0, input int y1);
        bit ok;
        @(posedge clk); #1;
        req_x0 = 9'(x0); req_x1 = 9'(x1); req_y0 = 9'(y0); req_y1 = 9'(y1);
        req_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("req_accept", 32'(ok), 32'd1);
    endtask

    task automatic wait_done(input int budget);
        bit fin;
        fin = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy) begin
                fin = 1'b1;
                break;
            end
        end
        chk("window_complete", 32'(fin), 32'd1);
        chk("byte_count", 32'(bytes_seen), 32'(exp_total));
        chk("req_ready_after", 32'(req_ready), 32'd1);
    endtask

    initial begin
        phy_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (!manual_ready) phy_ready = ($urandom_range(0, 99) < ready_rate);
        end
    end

    initial begin
        pix_valid = 1'b0;
        pix_data  = 16'h0000;
        forever begin
            @(negedge clk);
            take = pix_valid && pix_ready;
            @(posedge clk); #1;
            if (take && pix_q.size() > 0) void'(pix_q.pop_front());
            pix_valid = (pix_q.size() > 0) && ($urandom_range(0, 99) < pix_rate);
            pix_data  = (pix_q.size() > 0) ? pix_q[0] : 16'($urandom);
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            hs = phy_valid && phy_ready;
            if (!err_expected) begin
                chk("done_on_last_byte", 32'(done_stb), 32'(hs && exp_q.size() == 1));
                chk("err_quiet", 32'(err_stb), 32'd0);
            end
            if (prev_stall) begin
                chk("stall_hold", {23'd0, phy_valid, phy_rs, phy_data}, {23'd0, 1'b1, prev_byte});
            end
            if (hs) begin
                bytes_seen++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL phy_byte: got unexpected %0h, expected no byte at %0t",
                             {phy_rs, phy_data}, $time);
                end else begin
                    popped = exp_q.pop_front();
                    chk("phy_byte", {23'd0, phy_rs, phy_data}, {23'd0, popped});
                end
            end
            prev_stall = phy_valid && !phy_ready;
            prev_byte  = {phy_rs, phy_data};
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [8:0] held;
        int x0, x1, y0, y1;
        rst_n = 1'b0;
        req_valid = 1'b0;
        req_x0 = '0; req_x1 = '0; req_y0 = '0; req_y1 = '0;

        @(negedge clk);
        chk("rst_phy_valid", 32'(phy_valid), 32'd0);
        chk("rst_phy_data", 32'(phy_data), 32'd0);
        chk("rst_phy_rs", 32'(phy_rs), 32'd0);
        chk("rst_pix_ready", 32'(pix_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_strobes", {30'd0, done_stb, err_stb}, 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("req_ready_pre_clock", 32'(req_ready), 32'd0);
        @(negedge clk);
        chk("req_ready_post_clock", 32'(req_ready), 32'd1);

        // Directed two-pixel window with hand-derived bytes.
        ready_rate = 100; pix_rate = 100;
        pix_q.push_back(16'hF800);
        pix_q.push_back(16'h07E0);
        exp_q = '{9'h02A, 9'h100, 9'h100, 9'h100, 9'h101, 9'h02B, 9'h100, 9'h100,
                  9'h100, 9'h100, 9'h02C, 9'h1F8, 9'h100, 9'h107, 9'h1E0};
        exp_total = 15; bytes_seen = 0;
        issue_req(0, 1, 0, 0);
        wait_done(200);

        // PHY stall in the middle of the header.
        manual_ready = 1'b1;
        @(posedge clk); #1; phy_ready = 1'b1;
        push_window(5, 6, 3, 3);
        issue_req(5, 6, 3, 3);
        @(negedge clk);
        @(posedge clk); #1; phy_ready = 1'b0;
        @(negedge clk);
        held = {phy_rs, phy_data};
        chk("stall_valid", 32'(phy_valid), 32'd1);
        repeat (4) begin
            @(negedge clk);
            chk("stall_directed", {23'd0, phy_valid, phy_rs, phy_data}, {23'd0, 1'b1, held});
        end
        @(posedge clk); #1; phy_ready = 1'b1;
        manual_ready = 1'b0;
        wait_done(500);

        // Illegal request: x1 < x0.
        err_expected = 1'b1;
        issue_req(10, 5, 0, 0);
        @(negedge clk);
        chk("bad_done", 32'(done_stb), 32'd1);
        chk("bad_err", 32'(err_stb), 32'd1);
        chk("bad_no_byte", 32'(phy_valid), 32'd0);
        chk("bad_not_busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("bad_strobe_width", {30'd0, done_stb, err_stb}, 32'd0);
        chk("bad_req_ready", 32'(req_ready), 32'd1);
        chk("bad_no_byte_2", 32'(phy_valid), 32'd0);
        err_expected = 1'b0;

        // Random windows under random back-pressure, plus the far coordinate corner.
        ready_rate = 60; pix_rate = 60;
        for (int n = 0; n < 9; n++) begin
            if (n == 8) begin
                x0 = 509; x1 = 511; y0 = 510; y1 = 511;
            end else begin
                x0 = $urandom_range(0, 511);
                x1 = x0 + $urandom_range(0, 4);
                if (x1 > 511) x1 = 511;
                y0 = $urandom_range(0, 511);
                y1 = y0 + $urandom_range(0, 3);
                if (y1 > 511) y1 = 511;
            end
            push_window(x0, x1, y0, y1);
            issue_req(x0, x1, y0, y1);
            wait_done(4000);
        end

        // Reset during the third pixel of a 4x4 window.
        push_window(20, 23, 30, 33);
        issue_req(20, 23, 30, 33);
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (pix_q.size() <= 14) break;
        end
        chk("reached_pixel3", 32'(pix_q.size() <= 14), 32'd1);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("midrst_phy_valid", 32'(phy_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done_stb), 32'd0);
        exp_q.delete();
        pix_q.delete();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (3) @(negedge clk);

        push_window(7, 7, 9, 9);
        issue_req(7, 7, 9, 9);
        wait_done(500);
        chk("one_by_one_bytes", 32'(bytes_seen), 32'd13);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lcd_win_streamer.md
LCD_WIN_STREAMER -- requirements
Module: lcd_win_streamer

Interface
REQ-001 SHALL have parameter CMD_CASET, default 8'h2A, column-address-set opcode.
REQ-002 SHALL have parameter CMD_RASET, default 8'h2B, row-address-set opcode.
REQ-003 SHALL have parameter CMD_RAMWR, default 8'h2C, memory-write opcode.
REQ-004 SHALL have port clk  in  1  sole clock.
REQ-005 SHALL have port rst_n  in  1  reset; one clock, reset asynchronous and active-low.
REQ-006 SHALL have ports req_x0, req_x1, req_y0, req_y1  in  9 each  inclusive window corners.
REQ-007 SHALL have ports req_valid in 1 / req_ready out 1  window request handshake.
REQ-008 SHALL have ports pix_data in 16 / pix_valid in 1 / pix_ready out 1  RGB565 pixel stream.
REQ-009 SHALL have ports phy_data out 8 / phy_rs out 1 (0 = cmd, 1 = data) / phy_valid out 1 / phy_ready in 1  byte stream to LCD PHY.
REQ-010 SHALL have ports busy out 1, done_stb out 1, err_stb out 1  status.

Function
REQ-011 SHALL use FSM states IDLE, HDR, PIX_HI, PIX_LO; the only legal transitions are IDLE->HDR, HDR->PIX_HI, PIX_HI->PIX_LO, PIX_LO->PIX_HI and PIX_LO->IDLE.
REQ-012 SHALL assert req_ready only in IDLE; a request is accepted on req_valid & req_ready.
REQ-013 SHALL, on acceptance with x1<x0 or y1<y0, stay in IDLE, emit no bytes, and pulse done_stb and err_stb together for exactly one cycle, on the cycle after acceptance.
REQ-014 SHALL, on a legal request, register the corners and enter HDR, with phy_valid high the following cycle.
REQ-015 SHALL emit in HDR exactly 11 bytes: CMD_CASET(rs0), x0[15:8], x0[7:0], x1[15:8], x1[7:0] (rs1), CMD_RASET(rs0), y0 hi/lo, y1 hi/lo (rs1), CMD_RAMWR(rs0); coordinates zero-extended to 16 bits.
REQ-016 SHALL treat phy_* as a registered output slot: phy_data/phy_rs stay stable while phy_valid & !phy_ready; a byte is consumed on phy_valid & phy_ready.
REQ-017 SHALL load the output slot when it is empty or being consumed in the same cycle, sustaining one byte per cycle while phy_ready stays high.
REQ-018 SHALL assert pix_ready only in PIX_HI while the slot is free; on a pixel transfer, phy_data = pix_data[15:8] (rs1), pix_data[7:0] is latched, and the state moves to PIX_LO.
REQ-019 SHALL emit the latched low byte (rs1) in PIX_LO without consuming a pixel, then advance the column counter.
REQ-020 SHALL count columns x0..x1, wrapping to x0 with a row increment, and emit exactly (x1-x0+1)*(y1-y0+1) pixels using counters only (no multiplier).
REQ-021 SHALL, after the last low byte is consumed, return to IDLE and pulse done_stb for one cycle on that consumption cycle.
REQ-022 SHALL drive busy high in every state except IDLE.
REQ-023 SHALL handle a 1x1 window (x0=x1, y0=y1) as 11 header bytes + 2 pixel bytes.
REQ-024 SHALL pass pixel stalls (pix_valid low) and PHY stalls (phy_ready low) of any length without loss or duplication.

Reset
REQ-025 SHALL, while rst_n is low, immediately force: FSM to IDLE, phy_valid 0, phy_data 8'h00, phy_rs 0, pix_ready 0, busy 0, done_stb 0, err_stb 0, counters 0; req_ready rises on the first clock after release.
REQ-026 SHALL, on reset asserted mid-window, drop the in-flight byte and remaining pixels with no completion strobe.

Structure
REQ-027 SHALL take the DCS opcode values and the 9-bit coordinate width from a shared lcd_defs constants include, which other LCD blocks also use.
REQ-028 SHALL implement the header-byte selection as an 11-entry combinational mux indexed by a 4-bit counter; no sub-module.

Verification
REQ-029 Window (0,0)-(1,0), phy_ready=1, pixels 16'hF800, 16'h07E0 -> bytes 2A,00,00,00,01,2B,00,00,00,00,2C,F8,00,07,E0 with rs 0,1,1,1,1,0,1,1,1,1,0,1,1,1,1; done_stb one cycle.
REQ-030 Window (0,0)-(319,239) with random phy_ready/pix_valid -> exactly 76800 pixels, 153611 bytes, order preserved.
REQ-031 phy_ready held low 5 cycles mid-header -> phy_data/phy_rs/phy_valid unchanged across the stall.
REQ-032 Request x0=10, x1=5 -> no phy_valid, done_stb and err_stb high together for one cycle, req_ready back high.
REQ-033 rst_n pulsed low during pixel 3 of a 4x4 window -> phy_valid 0 asynchronously, no done_stb; a new 1x1 request then produces 13 correct bytes.
